// File: rtl/tlul_pkg.sv
// TL-UL opcodes, bridge state encoding and the byte-lane helper.
package tlul_pkg;

    localparam int TL_AW  = top_pkg::TL_AW;
    localparam int TL_DW  = top_pkg::TL_DW;
    localparam int TL_AIW = top_pkg::TL_AIW;
    localparam int TL_DIW = top_pkg::TL_DIW;
    localparam int TL_AUW = top_pkg::TL_AUW;
    localparam int TL_DUW = top_pkg::TL_DUW;
    localparam int TL_DBW = top_pkg::TL_DBW;
    localparam int TL_SZW = top_pkg::TL_SZW;

    // A-channel opcodes
    localparam logic [2:0] PutFullData    = 3'd0;
    localparam logic [2:0] PutPartialData = 3'd1;
    localparam logic [2:0] Get            = 3'd4;

    // D-channel opcodes
    localparam logic [2:0] AccessAck      = 3'd0;
    localparam logic [2:0] AccessAckData  = 3'd1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } bridge_state_e;

    // Byte lanes a naturally aligned access of 2^size bytes at addr_lsb covers.
    function automatic logic [TL_DBW-1:0] tl_lanes(input logic [TL_SZW-1:0] size,
                                                   input logic [1:0]        addr_lsb);
        logic [TL_DBW-1:0] lanes;
        case (size)
            2'd0:    lanes = 4'b0001 << addr_lsb;
            2'd1:    lanes = 4'b0011 << {addr_lsb[1], 1'b0};
            2'd2:    lanes = 4'b1111;
            default: lanes = 4'b0000;
        endcase
        return lanes;
    endfunction

endpackage

// File: rtl/top_pkg.sv
// Top-level TL-UL bus widths shared by every TL-UL endpoint in the system.
package top_pkg;

    localparam int TL_AW  = 32;
    localparam int TL_DW  = 32;
    localparam int TL_AIW = 8;
    localparam int TL_DIW = 1;
    localparam int TL_AUW = 16;
    localparam int TL_DUW = 16;
    localparam int TL_DBW = TL_DW / 8;
    localparam int TL_SZW = 2;

endpackage

// File: rtl/tlul_err_chk.sv
// Combinational TL-UL request legality check (opcode, size, alignment, mask).
module tlul_err_chk
    import tlul_pkg::*;
(
    input  logic [2:0]        opcode,
    input  logic [TL_SZW-1:0] size,
    input  logic [1:0]        addr_lsb,
    input  logic [TL_DBW-1:0] mask,
    output logic              err
);

    logic [TL_DBW-1:0] lanes_s;
    logic              op_err_s;
    logic              size_err_s;
    logic              align_err_s;
    logic              mask_err_s;

    assign lanes_s = tl_lanes(size, addr_lsb);

    // Flag every rule the request violates; any one of them makes it an error.
    always_comb begin
        op_err_s    = 1'b0;
        size_err_s  = 1'b0;
        align_err_s = 1'b0;
        mask_err_s  = 1'b0;

        case (opcode)
            PutFullData, PutPartialData, Get: op_err_s = 1'b0;
            default:                          op_err_s = 1'b1;
        endcase

        size_err_s = (size > 2'd2);

        case (size)
            2'd0:    align_err_s = 1'b0;
            2'd1:    align_err_s = addr_lsb[0];
            2'd2:    align_err_s = (addr_lsb != 2'd0);
            default: align_err_s = 1'b1;
        endcase

        if ((mask & ~lanes_s) != {TL_DBW{1'b0}}) begin
            mask_err_s = 1'b1;
        end else if ((opcode == PutFullData) && (mask != lanes_s)) begin
            mask_err_s = 1'b1;
        end else if ((opcode == Get) && (mask == {TL_DBW{1'b0}})) begin
            mask_err_s = 1'b1;
        end else begin
            mask_err_s = 1'b0;
        end

        err = op_err_s | size_err_s | align_err_s | mask_err_s;
    end

endmodule

// File: rtl/tlul_reg_bridge.sv
// TL-UL device port to zero-wait register interface bridge.
// One outstanding request; back-to-back throughput when d_ready_i stays high.
// Optional macro TLUL_REG_BRIDGE_ERRCHK_EN enables TL-UL protocol error checking;
// without it every request reaches the register interface.
module tlul_reg_bridge
    import tlul_pkg::*;
#(
    parameter int RegAw = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,

    input  logic              a_valid_i,
    input  logic [2:0]        a_opcode_i,
    input  logic [2:0]        a_param_i,
    input  logic [TL_SZW-1:0] a_size_i,
    input  logic [TL_AIW-1:0] a_source_i,
    input  logic [TL_AW-1:0]  a_address_i,
    input  logic [TL_DBW-1:0] a_mask_i,
    input  logic [TL_DW-1:0]  a_data_i,
    input  logic [TL_AUW-1:0] a_user_i,
    output logic              a_ready_o,

    output logic              d_valid_o,
    output logic [2:0]        d_opcode_o,
    output logic [2:0]        d_param_o,
    output logic [TL_SZW-1:0] d_size_o,
    output logic [TL_AIW-1:0] d_source_o,
    output logic [TL_DIW-1:0] d_sink_o,
    output logic [TL_DW-1:0]  d_data_o,
    output logic [TL_DUW-1:0] d_user_o,
    output logic              d_error_o,
    input  logic              d_ready_i,

    output logic              re_o,
    output logic              we_o,
    output logic [RegAw-1:0]  addr_o,
    output logic [TL_DW-1:0]  wdata_o,
    output logic [TL_DBW-1:0] be_o,
    input  logic [TL_DW-1:0]  rdata_i,
    input  logic              error_i
);

    bridge_state_e     state_r;
    bridge_state_e     state_s;
    logic              accept_s;
    logic              is_get_s;
    logic              is_write_s;
    logic              err_s;
    logic              rsp_err_s;
    logic [TL_DW-1:0]  rsp_data_s;

    logic [2:0]        d_opcode_r;
    logic [TL_SZW-1:0] d_size_r;
    logic [TL_AIW-1:0] d_source_r;
    logic [TL_DW-1:0]  d_data_r;
    logic              d_error_r;
    logic              unused_s;

`ifdef TLUL_REG_BRIDGE_ERRCHK_EN
    tlul_err_chk u_err_chk (
        .opcode   (a_opcode_i),
        .size     (a_size_i),
        .addr_lsb (a_address_i[1:0]),
        .mask     (a_mask_i),
        .err      (err_s)
    );
    assign is_write_s = (a_opcode_i == PutFullData) | (a_opcode_i == PutPartialData);
`else
    assign err_s      = 1'b0;
    assign is_write_s = (a_opcode_i != Get);
`endif

    // A response slot frees up in the same cycle the host takes the old one.
    assign a_ready_o = (state_r == ST_IDLE) | d_ready_i;
    assign accept_s  = a_valid_i & a_ready_o;
    assign is_get_s  = (a_opcode_i == Get);
    assign rsp_err_s = err_s | error_i;

    assign re_o    = accept_s & is_get_s & ~err_s;
    assign we_o    = accept_s & is_write_s & ~err_s;
    assign addr_o  = a_address_i[RegAw-1:0];
    assign wdata_o = a_data_i;
    assign be_o    = a_mask_i;

    assign d_valid_o  = (state_r == ST_RESP);
    assign d_opcode_o = d_opcode_r;
    assign d_param_o  = 3'd0;
    assign d_size_o   = d_size_r;
    assign d_source_o = d_source_r;
    assign d_sink_o   = {TL_DIW{1'b0}};
    assign d_data_o   = d_data_r;
    assign d_user_o   = {TL_DUW{1'b0}};
    assign d_error_o  = d_error_r;

    assign unused_s = ^{a_param_i, a_user_i, a_address_i[TL_AW-1:RegAw]};

    // Read data for the response: all-ones on a failed read, zero for writes.
    always_comb begin
        rsp_data_s = {TL_DW{1'b0}};
        if (is_get_s) begin
            if (rsp_err_s) begin
                rsp_data_s = {TL_DW{1'b1}};
            end else begin
                rsp_data_s = rdata_i;
            end
        end else begin
            rsp_data_s = {TL_DW{1'b0}};
        end
    end

    // Response-pending state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next state: stay in RESP while the response waits or a new one replaces it.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_s = ST_RESP;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RESP: begin
                if (d_ready_i && !accept_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_RESP;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // D payload is captured on accept and held until the next accept.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            d_opcode_r <= 3'd0;
            d_size_r   <= {TL_SZW{1'b0}};
            d_source_r <= {TL_AIW{1'b0}};
            d_data_r   <= {TL_DW{1'b0}};
            d_error_r  <= 1'b0;
        end else if (accept_s) begin
            d_opcode_r <= is_get_s ? AccessAckData : AccessAck;
            d_size_r   <= a_size_i;
            d_source_r <= a_source_i;
            d_data_r   <= rsp_data_s;
            d_error_r  <= rsp_err_s;
        end else begin
            d_opcode_r <= d_opcode_r;
            d_size_r   <= d_size_r;
            d_source_r <= d_source_r;
            d_data_r   <= d_data_r;
            d_error_r  <= d_error_r;
        end
    end

endmodule

// File: tb/tb_tlul_reg_bridge.sv
// Testbench for tlul_reg_bridge (honours TLUL_REG_BRIDGE_ERRCHK_EN like the RTL).
module tb_tlul_reg_bridge;
    import top_pkg::*;

    logic              clk;
    logic              rst_n;
    logic              a_valid;
    logic [2:0]        a_opcode;
    logic [2:0]        a_param;
    logic [TL_SZW-1:0] a_size;
    logic [TL_AIW-1:0] a_source;
    logic [TL_AW-1:0]  a_address;
    logic [TL_DBW-1:0] a_mask;
    logic [TL_DW-1:0]  a_data;
    logic [TL_AUW-1:0] a_user;
    logic              a_ready_o;
    logic              d_valid_o;
    logic [2:0]        d_opcode_o;
    logic [2:0]        d_param_o;
    logic [TL_SZW-1:0] d_size_o;
    logic [TL_AIW-1:0] d_source_o;
    logic [TL_DIW-1:0] d_sink_o;
    logic [TL_DW-1:0]  d_data_o;
    logic [TL_DUW-1:0] d_user_o;
    logic              d_error_o;
    logic              d_ready;
    logic              re_o;
    logic              we_o;
    logic [7:0]        addr_o;
    logic [TL_DW-1:0]  wdata_o;
    logic [TL_DBW-1:0] be_o;
    logic [TL_DW-1:0]  rdata;
    logic              error_in;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [2:0]        op;
        logic [TL_SZW-1:0] size;
        logic [TL_AIW-1:0] src;
        logic [TL_DW-1:0]  data;
        logic              err;
    } rsp_t;

    rsp_t exp_q[$];

    tlul_reg_bridge #(.RegAw(8)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .a_valid_i(a_valid), .a_opcode_i(a_opcode), .a_param_i(a_param),
        .a_size_i(a_size), .a_source_i(a_source), .a_address_i(a_address),
        .a_mask_i(a_mask), .a_data_i(a_data), .a_user_i(a_user),
        .a_ready_o(a_ready_o),
        .d_valid_o(d_valid_o), .d_opcode_o(d_opcode_o), .d_param_o(d_param_o),
        .d_size_o(d_size_o), .d_source_o(d_source_o), .d_sink_o(d_sink_o),
        .d_data_o(d_data_o), .d_user_o(d_user_o), .d_error_o(d_error_o),
        .d_ready_i(d_ready),
        .re_o(re_o), .we_o(we_o), .addr_o(addr_o), .wdata_o(wdata_o), .be_o(be_o),
        .rdata_i(rdata), .error_i(error_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference behaviour of one request, straight from the TL-UL rules.
    function automatic void model(input logic [2:0] op, input logic [1:0] size,
                                  input logic [31:0] addr, input logic [3:0] mask,
                                  input logic [31:0] rd_data, input logic err_in,
                                  output logic err, output logic rd, output logic wr,
                                  output logic [2:0] d_op, output logic [31:0] d_data);
        int nbytes, off, lanes;
        bit legal;
        nbytes = 1 << int'(size);
        off    = int'(addr[1:0]);
        lanes  = ((1 << nbytes) - 1) << off;
        legal  = (op == 3'd0) || (op == 3'd1) || (op == 3'd4);
`ifdef TLUL_REG_BRIDGE_ERRCHK_EN
        err = !legal || (size > 2'd2) || ((off % nbytes) != 0)
              || ((int'(mask) & ~lanes) != 0)
              || ((op == 3'd0) && (int'(mask) != lanes))
              || ((op == 3'd4) && (mask == 4'd0));
        wr  = (op == 3'd0) || (op == 3'd1);
`else
        err = 1'b0;
        wr  = (op != 3'd4);
`endif
        rd     = (op == 3'd4);
        d_op   = rd ? 3'd1 : 3'd0;
        d_data = rd ? ((err || err_in) ? 32'hFFFF_FFFF : rd_data) : 32'd0;
    endfunction

    // Per-cycle comparison of every DUT output against the reference model.
    always @(negedge clk) begin : compare
        logic exp_ready, acc, m_err, m_rd, m_wr;
        logic [2:0] m_op;
        logic [31:0] m_data;
        rsp_t r;
        if (!rst_n) begin
            chk("reset_d_valid", d_valid_o, 1'b0);
            exp_q.delete();
        end else begin
            exp_ready = (exp_q.size() == 0) || d_ready;
            acc = a_valid && exp_ready;
            model(a_opcode, a_size, a_address, a_mask, rdata, error_in, m_err, m_rd, m_wr, m_op, m_data);
            chk("a_ready", a_ready_o, exp_ready);
            chk("re", re_o, acc && m_rd && !m_err);
            chk("we", we_o, acc && m_wr && !m_err);
            chk("addr", addr_o, a_address[7:0]);
            chk("wdata", wdata_o, a_data);
            chk("be", be_o, a_mask);
            chk("d_valid", d_valid_o, exp_q.size() != 0);
            chk("d_const", {d_param_o, d_sink_o, d_user_o}, 0);
            if (exp_q.size() != 0) begin
                chk("d_opcode", d_opcode_o, exp_q[0].op);
                chk("d_size", d_size_o, exp_q[0].size);
                chk("d_source", d_source_o, exp_q[0].src);
                chk("d_data", d_data_o, exp_q[0].data);
                chk("d_error", d_error_o, exp_q[0].err);
                if (d_ready) void'(exp_q.pop_front());
            end
            if (acc) begin
                r.op = m_op; r.size = a_size; r.src = a_source;
                r.data = m_data; r.err = m_err || error_in;
                exp_q.push_back(r);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_a(input logic v, input logic [2:0] op, input logic [1:0] sz,
                         input logic [7:0] src, input logic [31:0] addr,
                         input logic [3:0] mask, input logic [31:0] data);
        a_valid = v; a_opcode = op; a_size = sz; a_source = src;
        a_address = addr; a_mask = mask; a_data = data;
        a_param = 3'd0; a_user = 16'd0;
    endtask

    initial begin : stim
        logic e, rd, wr;
        logic [2:0] op;
        logic [31:0] dd;
        int lanes;
        rst_n = 1'b1; d_ready = 1'b1; rdata = 32'd0; error_in = 1'b0;
        set_a(1'b0, 3'd0, 2'd0, 8'd0, 32'd0, 4'd0, 32'd0);
        #1 rst_n = 1'b0;
        #2;
        chk("rst_d_valid", d_valid_o, 1'b0);
        chk("rst_a_ready", a_ready_o, 1'b1);
        chk("rst_payload", {d_opcode_o, d_size_o, d_source_o, d_data_o, d_error_o}, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Model pins against hand-computed values.
        model(3'd4, 2'd2, 32'h10, 4'hF, 32'hDEADBEEF, 1'b0, e, rd, wr, op, dd);
        chk("model_get", {e, rd, wr, op, dd}, {1'b0, 1'b1, 1'b0, 3'd1, 32'hDEADBEEF});
        model(3'd1, 2'd1, 32'h06, 4'hC, 32'h0, 1'b0, e, rd, wr, op, dd);
        chk("model_putpart", {e, rd, wr, op, dd}, {1'b0, 1'b0, 1'b1, 3'd0, 32'd0});

        // Get 0x10
        tick(); set_a(1'b1, 3'd4, 2'd2, 8'd5, 32'h10, 4'hF, 32'd0); rdata = 32'hDEADBEEF; d_ready = 1'b1;
        #2 chk("t1_re", re_o, 1'b1); chk("t1_addr", addr_o, 8'h10); chk("t1_we", we_o, 1'b0);
        tick(); a_valid = 1'b0;
        #2 chk("t1_rsp", {d_valid_o, d_opcode_o, d_data_o, d_error_o, d_source_o},
                {1'b1, 3'd1, 32'hDEADBEEF, 1'b0, 8'd5});
        // PutPartialData
        set_a(1'b1, 3'd1, 2'd1, 8'd6, 32'h06, 4'hC, 32'h12340000);
        #1 chk("t2_we", {we_o, be_o, wdata_o}, {1'b1, 4'hC, 32'h12340000});
        tick(); a_valid = 1'b0;
        #2 chk("t2_rsp", {d_valid_o, d_opcode_o, d_error_o, d_data_o}, {1'b1, 3'd0, 1'b0, 32'd0});
        // PutFullData with partial mask, then Get of size 3
        tick(); set_a(1'b1, 3'd0, 2'd2, 8'd3, 32'h0, 4'h7, 32'hA5A5A5A5);
`ifdef TLUL_REG_BRIDGE_ERRCHK_EN
        #2 chk("t3_we", we_o, 1'b0);
        tick(); set_a(1'b1, 3'd4, 2'd3, 8'd4, 32'h0, 4'hF, 32'd0); rdata = 32'h55AA55AA;
        #2 chk("t3_put_rsp", {d_opcode_o, d_error_o}, {3'd0, 1'b1});
        chk("t3_re", re_o, 1'b0);
        tick(); a_valid = 1'b0;
        #2 chk("t3_get_rsp", {d_error_o, d_data_o}, {1'b1, 32'hFFFFFFFF});
`else
        #2 chk("t3_we", we_o, 1'b1);
        tick(); set_a(1'b1, 3'd4, 2'd3, 8'd4, 32'h0, 4'hF, 32'd0); rdata = 32'h55AA55AA;
        #2 chk("t3_put_rsp", {d_opcode_o, d_error_o}, {3'd0, 1'b0});
        chk("t3_re", re_o, 1'b1);
        tick(); a_valid = 1'b0;
        #2 chk("t3_get_rsp", {d_error_o, d_data_o}, {1'b0, 32'h55AA55AA});
`endif
        // Backpressure for 3 cycles
        tick(); set_a(1'b1, 3'd4, 2'd2, 8'd7, 32'h20, 4'hF, 32'd0); rdata = 32'hCAFEF00D; d_ready = 1'b0;
        #2 chk("t4_re0", re_o, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick(); set_a(1'b1, 3'd4, 2'd2, 8'd8, 32'h24, 4'hF, 32'd0); rdata = 32'h11111111;
            #2 chk("t4_stall", {a_ready_o, re_o, d_valid_o, d_data_o, d_source_o},
                   {1'b0, 1'b0, 1'b1, 32'hCAFEF00D, 8'd7});
        end
        tick(); d_ready = 1'b1; rdata = 32'h22222222;
        #2 chk("t4_release", {a_ready_o, re_o}, {1'b1, 1'b1});
        tick(); a_valid = 1'b0;
        #2 chk("t4_rsp2", {d_valid_o, d_source_o, d_data_o}, {1'b1, 8'd8, 32'h22222222});
        // Four back-to-back Gets
        for (int k = 1; k <= 4; k++) begin
            tick(); set_a(1'b1, 3'd4, 2'd2, 8'(k), 32'(4 * k), 4'hF, 32'd0); rdata = 32'(k) * 32'h01010101;
            if (k > 1) begin
                #2 chk("t5_src", {d_valid_o, d_source_o}, {1'b1, 8'(k - 1)});
            end
        end
        tick(); a_valid = 1'b0;
        #2 chk("t5_src", {d_valid_o, d_source_o, d_data_o}, {1'b1, 8'd4, 32'h04040404});
        tick();
        #2 chk("t5_idle", d_valid_o, 1'b0);
        // Reset while a response is pending
        tick(); set_a(1'b1, 3'd4, 2'd2, 8'd9, 32'h30, 4'hF, 32'd0); d_ready = 1'b0;
        tick(); a_valid = 1'b0;
        #1 chk("t6_pend", d_valid_o, 1'b1);
        #1 rst_n = 1'b0;
        #1 chk("t6_async", d_valid_o, 1'b0);
        tick(); tick(); rst_n = 1'b1; d_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            #2 chk("t6_after", {a_ready_o, d_valid_o}, {1'b1, 1'b0});
        end

        // Randomized traffic
        for (int c = 0; c < 400; c++) begin
            int r;
            tick();
            r = $urandom_range(0, 9);
            a_opcode = (r < 3) ? 3'd0 : (r < 6) ? 3'd1 : (r < 9) ? 3'd4 : 3'($urandom_range(0, 7));
            a_size = ($urandom_range(0, 9) < 8) ? 2'($urandom_range(0, 2)) : 2'd3;
            a_address = $urandom();
            if ($urandom_range(0, 9) < 7) a_address = a_address & ~((32'd1 << a_size) - 32'd1);
            lanes = ((1 << (1 << int'(a_size))) - 1) << int'(a_address[1:0]);
            a_mask = ($urandom_range(0, 9) < 7) ? 4'(lanes) : 4'($urandom_range(0, 15));
            a_valid = ($urandom_range(0, 9) < 6);
            a_source = 8'($urandom()); a_data = $urandom();
            a_param = 3'($urandom()); a_user = 16'($urandom());
            d_ready = ($urandom_range(0, 9) < 7);
            rdata = $urandom();
            error_in = ($urandom_range(0, 15) == 0);
        end
        tick(); a_valid = 1'b0; d_ready = 1'b1; error_in = 1'b0;
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tlul_reg_bridge.md
Name: tlul_reg_bridge

Overview:
- Downstream TL-UL consumer. Terminates one TL-UL device port and drives a simple zero-wait register interface, e.g. the rv_plic register file.
- All bus widths come from top_pkg: TL_AW, TL_DW, TL_AIW, TL_DIW, TL_AUW, TL_DUW, TL_DBW, TL_SZW.
- Accepts one outstanding request, performs protocol error checking and returns one AccessAck/AccessAckData per accepted request.

Parameters:
- RegAw, 8: register address width; addr_o = a_address_i[RegAw-1:0].

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- a_valid_i  in  1  A-channel valid
- a_opcode_i  in  3  0=PutFullData, 1=PutPartialData, 4=Get
- a_param_i  in  3  ignored
- a_size_i  in  TL_SZW  log2 bytes
- a_source_i  in  TL_AIW  request ID
- a_address_i  in  TL_AW  byte address
- a_mask_i  in  TL_DBW  byte lanes
- a_data_i  in  TL_DW  write data
- a_user_i  in  TL_AUW  ignored
- a_ready_o  out  1  A-channel ready
- d_valid_o  out  1  D-channel valid
- d_opcode_o  out  3  0=AccessAck, 1=AccessAckData
- d_param_o  out  3  constant 0
- d_size_o  out  TL_SZW  echo of a_size
- d_source_o  out  TL_AIW  echo of a_source
- d_sink_o  out  TL_DIW  constant 0
- d_data_o  out  TL_DW  read data
- d_user_o  out  TL_DUW  constant 0
- d_error_o  out  1  error response
- d_ready_i  in  1  D-channel ready
- re_o  out  1  register read strobe
- we_o  out  1  register write strobe
- addr_o  out  RegAw  register byte address
- wdata_o  out  TL_DW  write data
- be_o  out  TL_DBW  byte enables
- rdata_i  in  TL_DW  read data, same cycle as re_o
- error_i  in  1  register-side error, same cycle as re_o/we_o

Behaviour:
- Reset (async, rst_ni low): rsp_pending=0, d_valid_o=0, all D payload registers 0. A reset mid-response drops the pending response silently.
- States:
  - IDLE (rsp_pending=0)
  - RESP (rsp_pending=1)
- Handshake:
  - a_ready_o = ~rsp_pending | d_ready_i.
  - Accept when a_valid_i & a_ready_o.
  - d_valid_o = rsp_pending.
  - Response completes on d_valid_o & d_ready_i.
- Transitions:
  - IDLE→RESP on accept.
  - RESP→IDLE on response completion without a new accept.
  - RESP→RESP on completion and accept in the same cycle. The new response is loaded; there are no bubbles, giving one transaction per cycle at full throughput.
- Strobes: combinational in the accept cycle only.
  - we_o = accept & (opcode 0 or 1) & ~err.
  - re_o = accept & opcode 4 & ~err.
  - addr_o, wdata_o and be_o pass through combinationally from A.
- err is asserted for any of:
  - opcode not in {0,1,4}
  - a_size_i > 2
  - a_address_i not aligned to 2^a_size_i
  - a_mask_i has bits outside the lanes implied by address[1:0] and size
  - PutFullData with a_mask_i not equal to the implied lanes
  - Get with a_mask_i = 0
- Response registered in the accept cycle (latency: d_valid_o one cycle after accept):
  - d_opcode_o = 1 for Get, else 0 (also for illegal opcodes).
  - d_size_o and d_source_o are echoed from the request.
  - d_error_o = err | error_i.
- d_data_o:
  - Get without error: rdata_i.
  - Get with error: all-ones.
  - Writes: 0.
- D payload is held stable while d_valid_o=1 & ~d_ready_i.
- A-channel inputs are don't-care when a_valid_i=0.

Optional Feature:
- Macro: TLUL_REG_BRIDGE_ERRCHK_EN.
- Defined: full protocol error checking as above.
- Undefined:
  - err is tied to 0; all requests reach the register interface.
  - Any opcode other than 4 is treated as a write.
  - d_error_o = error_i only.

Decomposition:
- Opcode constants and TL-UL width localparams live in a shared package, tlul_pkg: PutFullData, PutPartialData, Get, AccessAck, AccessAckData.
- The package imports top_pkg widths.
- One natural sub-module: tlul_err_chk, a combinational err computation from opcode/size/address/mask, instantiated only under the macro.

Test Plan:
- Get addr 0x10, size 2, mask 0xF; rdata_i=0xDEADBEEF → re_o pulses 1 cycle with addr_o=0x10; next cycle d_valid_o=1, opcode 1, data 0xDEADBEEF, error 0, source echoed.
- PutPartialData addr 0x06, size 1, mask 0xC, data 0x12340000 → we_o=1, be_o=0xC; response opcode 0, d_error_o=0.
- PutFullData size 2 with mask 0x7 (macro on) → no we_o; response d_error_o=1, opcode 0. Get with size 3 → d_error_o=1, d_data_o=0xFFFFFFFF.
- Hold d_ready_i=0 for 3 cycles after a Get → a_ready_o=0, D payload stable; the next request is not accepted until d_ready_i=1.
- d_ready_i=1 tied, 4 back-to-back Gets with sources 1..4 → 4 responses on consecutive cycles, sources 1..4 in order.
- Assert rst_ni low while d_valid_o=1 → d_valid_o drops immediately (async); after release a_ready_o=1 and no stale response appears.
